// File: rtl/abp_pkg.sv
// ---------------------------------------------------------------------------
// abp_pkg
// Types and defaults shared by the ABP receive-side sequencing controller and
// its ACK framer.
//   abp_ctrl_state_t : controller FSM states
//   ABP_FRAME_BYTES  : data/ACK frame length in bytes
//   ABP_ACK_MARKER   : default value of ACK byte 0
// ---------------------------------------------------------------------------
package abp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DELIVER  = 2'd1,
    SEND_ACK = 2'd2
  } abp_ctrl_state_t;

  localparam int         ABP_FRAME_BYTES = 64;
  localparam logic [7:0] ABP_ACK_MARKER  = 8'hAC;

endpackage

// File: rtl/abp_ack_framer.sv
// ---------------------------------------------------------------------------
// abp_ack_framer
// Emits one ACK frame on an AXI-Stream master per start pulse:
//   byte 0 = ACK_MARKER, bytes 1..ACK_BYTES-2 = 8'h00,
//   byte ACK_BYTES-1 = {7'b0, ack_bit} with tlast.
// Ports:
//   aclk, aresetn   : clock, asynchronous active-low reset
//   i_start         : one-cycle pulse, begin a new ACK (framer must be idle)
//   i_ack_bit       : alternating bit carried in the last byte (taken on start)
//   o_done          : one-cycle pulse coincident with the tlast handshake
//   m_axis_*        : AXI-Stream master (tvalid/tdata/tlast are registered)
// ---------------------------------------------------------------------------
module abp_ack_framer
  import abp_pkg::*;
#(
  parameter int         ACK_BYTES  = ABP_FRAME_BYTES,
  parameter logic [7:0] ACK_MARKER = ABP_ACK_MARKER
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       i_start,
  input  logic       i_ack_bit,
  output logic       o_done,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic [7:0] m_axis_tdata
);

  localparam int             IDX_W    = $clog2(ACK_BYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ACK_BYTES - 1);

  logic [IDX_W-1:0] r_idx;
  logic             r_ack_bit;
  logic             r_tvalid;
  logic             r_tlast;
  logic [7:0]       r_tdata;

  logic             w_hs;
  logic [IDX_W-1:0] w_next_idx;
  logic             w_next_is_last;

  assign w_hs           = r_tvalid & m_axis_tready;
  assign w_next_idx     = r_idx + 1'b1;
  assign w_next_is_last = (w_next_idx == LAST_IDX);

  // Done is combinational so the controller returns to IDLE on the same edge
  // that retires the last byte.
  assign o_done = w_hs & r_tlast;

  // The byte on the bus is always precomputed for the current index, so
  // tvalid/tdata/tlast only move on a handshake and stay put while stalled.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_idx     <= '0;
      r_ack_bit <= 1'b0;
      r_tvalid  <= 1'b0;
      r_tlast   <= 1'b0;
      r_tdata   <= 8'h00;
    end else if (i_start) begin
      r_idx     <= '0;
      r_ack_bit <= i_ack_bit;
      r_tvalid  <= 1'b1;
      r_tlast   <= 1'b0;
      r_tdata   <= ACK_MARKER;
    end else if (w_hs) begin
      if (r_tlast) begin
        r_idx    <= '0;
        r_tvalid <= 1'b0;
        r_tlast  <= 1'b0;
        r_tdata  <= 8'h00;
      end else begin
        r_idx   <= w_next_idx;
        r_tlast <= w_next_is_last;
        r_tdata <= w_next_is_last ? {7'b0, r_ack_bit} : 8'h00;
      end
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tdata  = r_tdata;

endmodule

// File: rtl/abp_receiver_controller.sv
// ---------------------------------------------------------------------------
// abp_receiver_controller
// ABP receive-side sequencing: owns expected_bit, classifies each checked
// frame as new / duplicate / malformed, delivers new values over valid/ready,
// acknowledges every accepted frame and re-sends the last ACK after an idle
// timeout.
// Ports:
//   aclk, aresetn              : clock, asynchronous active-low reset
//   rx_frame_valid/bit/error/value : checked-frame pulse from the receiver
//   expected_bit               : bit a new frame must carry
//   value_valid/ready/data     : consumer port
//   m_axis_tvalid/tready/tlast/tdata : ACK stream
//   dup_count/err_count/drop_count   : saturating statistics
// ---------------------------------------------------------------------------
module abp_receiver_controller
  import abp_pkg::*;
#(
  parameter int         ACK_BYTES     = ABP_FRAME_BYTES,
  parameter logic [7:0] ACK_MARKER    = ABP_ACK_MARKER,
  parameter int         REACK_TIMEOUT = 1000000,
  parameter int         CNT_W         = 16
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic             rx_frame_valid,
  input  logic             rx_frame_bit,
  input  logic             rx_frame_error,
  input  logic [63:0]      rx_frame_value,
  output logic             expected_bit,
  output logic             value_valid,
  input  logic             value_ready,
  output logic [63:0]      value_data,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tlast,
  output logic [7:0]       m_axis_tdata,
  output logic [CNT_W-1:0] dup_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] drop_count
);

  localparam int             TMR_W    = (REACK_TIMEOUT > 1) ? $clog2(REACK_TIMEOUT + 1) : 1;
  localparam bit             REACK_EN = (REACK_TIMEOUT != 0);
  // Timer fires on the edge where it would reach REACK_TIMEOUT.
  localparam logic [TMR_W-1:0] TMR_LAST = REACK_EN ? TMR_W'(REACK_TIMEOUT - 1) : '0;

  abp_ctrl_state_t  r_state;
  logic             r_expected_bit;
  logic             r_ack_bit;
  logic             r_ack_sent;
  logic [TMR_W-1:0] r_timer;
  logic             r_value_valid;
  logic [63:0]      r_value_data;
  logic [CNT_W-1:0] r_dup_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic w_frame_dup;
  logic w_deliver_hs;
  logic w_timer_fire;
  logic w_ack_start;
  logic w_start_bit;
  logic w_ack_done;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Every transition into SEND_ACK also launches the framer on the same edge;
  // this is what gives the 2-cycle frame-to-first-ACK-byte latency.
  assign w_frame_dup  = (r_state == IDLE) && rx_frame_valid && !rx_frame_error &&
                        (rx_frame_bit != r_expected_bit);
  assign w_deliver_hs = (r_state == DELIVER) && value_ready;
  // An arriving frame always wins over a timer expiring in the same cycle.
  assign w_timer_fire = REACK_EN && (r_state == IDLE) && r_ack_sent &&
                        !rx_frame_valid && (r_timer == TMR_LAST);
  assign w_ack_start  = w_frame_dup | w_deliver_hs | w_timer_fire;
  assign w_start_bit  = w_frame_dup  ? rx_frame_bit   :
                        w_deliver_hs ? r_expected_bit : r_ack_bit;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state        <= IDLE;
      r_expected_bit <= 1'b0;
      r_ack_bit      <= 1'b0;
      r_ack_sent     <= 1'b0;
      r_timer        <= '0;
      r_value_valid  <= 1'b0;
      r_value_data   <= '0;
      r_dup_cnt      <= '0;
      r_err_cnt      <= '0;
      r_drop_cnt     <= '0;
    end else begin
      if (rx_frame_valid) begin
        r_timer <= '0;
      end
      case (r_state)
        IDLE: begin
          if (rx_frame_valid) begin
            // Malformed frames are rejected before the bit is even looked at.
            if (rx_frame_error) begin
              r_err_cnt <= sat_inc(r_err_cnt);
            end else if (rx_frame_bit == r_expected_bit) begin
              r_value_data  <= rx_frame_value;
              r_value_valid <= 1'b1;
              r_state       <= DELIVER;
            end else begin
              r_dup_cnt <= sat_inc(r_dup_cnt);
              r_ack_bit <= rx_frame_bit;
              r_state   <= SEND_ACK;
            end
          end else if (REACK_EN && r_ack_sent) begin
            if (r_timer == TMR_LAST) begin
              r_timer <= '0;
              r_state <= SEND_ACK;
            end else begin
              r_timer <= r_timer + 1'b1;
            end
          end
        end
        DELIVER: begin
          if (rx_frame_valid) begin
            r_drop_cnt <= sat_inc(r_drop_cnt);
          end
          if (value_ready) begin
            r_value_valid  <= 1'b0;
            r_ack_bit      <= r_expected_bit;
            r_expected_bit <= ~r_expected_bit;
            r_state        <= SEND_ACK;
          end
        end
        SEND_ACK: begin
          if (rx_frame_valid) begin
            r_drop_cnt <= sat_inc(r_drop_cnt);
          end
          if (w_ack_done) begin
            r_ack_sent <= 1'b1;
            r_timer    <= '0;
            r_state    <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  abp_ack_framer #(
    .ACK_BYTES  (ACK_BYTES),
    .ACK_MARKER (ACK_MARKER)
  ) u_framer (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .i_start       (w_ack_start),
    .i_ack_bit     (w_start_bit),
    .o_done        (w_ack_done),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tdata  (m_axis_tdata)
  );

  assign expected_bit = r_expected_bit;
  assign value_valid  = r_value_valid;
  assign value_data   = r_value_data;
  assign dup_count    = r_dup_cnt;
  assign err_count    = r_err_cnt;
  assign drop_count   = r_drop_cnt;

endmodule

// File: tb/tb_abp_receiver_controller.sv
// ---------------------------------------------------------------------------
// tb_abp_receiver_controller
// Randomized and directed stimulus against a transaction-level model of the
// ABP receive controller (expected bit, saturating counters, queue of ACK
// bits that must appear on the stream). A negedge monitor checks every ACK
// byte, tlast placement and stall stability.
// ---------------------------------------------------------------------------
module tb_abp_receiver_controller;

  localparam int ACK_BYTES = 64;
  localparam int REACK     = 50;
  localparam int CNT_W     = 4;
  localparam int MAXC      = (1 << CNT_W) - 1;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic             rx_frame_valid = 1'b0;
  logic             rx_frame_bit = 1'b0;
  logic             rx_frame_error = 1'b0;
  logic [63:0]      rx_frame_value = '0;
  logic             expected_bit;
  logic             value_valid;
  logic             value_ready = 1'b0;
  logic [63:0]      value_data;
  logic             m_axis_tvalid;
  logic             m_axis_tready;
  logic             m_axis_tlast;
  logic [7:0]       m_axis_tdata;
  logic [CNT_W-1:0] dup_count;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] drop_count;

  always #5 aclk = ~aclk;

  abp_receiver_controller #(
    .ACK_BYTES     (ACK_BYTES),
    .ACK_MARKER    (8'hAC),
    .REACK_TIMEOUT (REACK),
    .CNT_W         (CNT_W)
  ) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .rx_frame_valid (rx_frame_valid),
    .rx_frame_bit   (rx_frame_bit),
    .rx_frame_error (rx_frame_error),
    .rx_frame_value (rx_frame_value),
    .expected_bit   (expected_bit),
    .value_valid    (value_valid),
    .value_ready    (value_ready),
    .value_data     (value_data),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tdata   (m_axis_tdata),
    .dup_count      (dup_count),
    .err_count      (err_count),
    .drop_count     (drop_count)
  );

  int asserts = 0;
  int fails   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    asserts++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  bit m_exp      = 1'b0;
  bit m_last_ack = 1'b0;
  int m_dup = 0, m_err = 0, m_drop = 0;
  bit ack_q[$];
  int n_tr = 0;

  function automatic int sat(input int v);
    return (v < MAXC) ? v + 1 : MAXC;
  endfunction

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // ---------------- ACK monitor ----------------
  int       cyc = 0, mon_idx = 0, acks_done = 0, hs_total = 0;
  int       mon_last_cyc = 0, mon_first_cyc = 0;
  bit       mon_stall = 0, mon_started = 0, mon_bit = 0;
  logic [9:0] mon_hold = '0;

  initial begin
    forever begin
      @(negedge aclk);
      cyc++;
      if (!aresetn) begin
        mon_idx     = 0;
        mon_stall   = 0;
        mon_started = 0;
      end else begin
        if (mon_stall)
          check_eq("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, mon_hold);
        mon_stall = m_axis_tvalid && !m_axis_tready;
        mon_hold  = {m_axis_tvalid, m_axis_tlast, m_axis_tdata};
        if (m_axis_tvalid && mon_idx == 0 && !mon_started) begin
          mon_started   = 1;
          mon_first_cyc = cyc;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (mon_idx == 0) begin
            if (ack_q.size() == 0) begin
              check_eq("ack_expected", 0, 1);
              mon_bit = 0;
            end else begin
              mon_bit = ack_q[0];
            end
          end
          check_eq("ack_byte", m_axis_tdata,
                   (mon_idx == 0) ? 64'hAC : (mon_idx == ACK_BYTES-1) ? {63'b0, mon_bit} : 64'h0);
          check_eq("ack_tlast", m_axis_tlast, (mon_idx == ACK_BYTES-1));
          hs_total++;
          if (mon_idx == ACK_BYTES-1) begin
            if (ack_q.size() > 0) void'(ack_q.pop_front());
            mon_idx      = 0;
            mon_started  = 0;
            mon_last_cyc = cyc;
            acks_done++;
          end else begin
            mon_idx++;
          end
        end
      end
    end
  end

  // ---------------- tready driver ----------------
  int tr_mode = 0;  // 0 random, 1 toggle + stall at byte 30, 2 always 1, 3 always 0
  int stall_n = 0;
  initial begin
    m_axis_tready = 1'b0;
    forever begin
      @(posedge aclk);
      #1;
      case (tr_mode)
        1: begin
          if (mon_idx == 30 && stall_n < 10) begin
            m_axis_tready = 1'b0;
            stall_n++;
          end else begin
            m_axis_tready = !m_axis_tready;
          end
        end
        2: m_axis_tready = 1'b1;
        3: m_axis_tready = 1'b0;
        default: m_axis_tready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // ---------------- helpers ----------------
  task automatic pulse(input logic err, input logic b, input logic [63:0] v);
    rx_frame_valid = 1'b1;
    rx_frame_error = err;
    rx_frame_bit   = b;
    rx_frame_value = v;
    tick();
    rx_frame_valid = 1'b0;
    rx_frame_error = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((ack_q.size() != 0 || m_axis_tvalid) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) check_eq("idle_timeout", 0, 1);
  endtask

  task automatic check_counters();
    check_eq("expected_bit", expected_bit, m_exp);
    check_eq("dup_count", dup_count, m_dup);
    check_eq("err_count", err_count, m_err);
    check_eq("drop_count", drop_count, m_drop);
  endtask

  task automatic send_frame(input logic err, input logic b, input logic [63:0] v, input int rdly);
    string kind;
    if (err) begin
      kind  = "error";
      m_err = sat(m_err);
    end else if (b == m_exp) begin
      kind = "new";
      ack_q.push_back(b);
      m_last_ack = b;
    end else begin
      kind  = "dup";
      m_dup = sat(m_dup);
      ack_q.push_back(b);
      m_last_ack = b;
    end
    pulse(err, b, v);
    if (kind == "new") begin
      check_eq("value_valid", value_valid, 1);
      check_eq("value_data", value_data, v);
      for (int i = 0; i < rdly; i++) begin
        tick();
        check_eq("hold_valid", value_valid, 1);
        check_eq("hold_data", value_data, v);
      end
      value_ready = 1'b1;
      tick();
      value_ready = 1'b0;
      m_exp = !m_exp;
      check_eq("valid_cleared", value_valid, 0);
    end else begin
      check_eq("no_delivery", value_valid, 0);
    end
    n_tr++;
    $display("frame %0d: %s bit=%0b err=%0b value=%h ready_delay=%0d", n_tr, kind, b, err, v, rdly);
    wait_idle();
    check_counters();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [63:0] v;
    bit          b, sticky;
    int          t0, n0, h0, n;

    repeat (3) tick();
    check_eq("rst_tvalid", m_axis_tvalid, 0);
    check_eq("rst_tlast", m_axis_tlast, 0);
    check_eq("rst_tdata", m_axis_tdata, 0);
    check_eq("rst_value_valid", value_valid, 0);
    check_eq("rst_value_data", value_data, 0);
    check_counters();
    aresetn = 1'b1;
    tick();

    // Malformed frame: counted, never acknowledged.
    send_frame(1'b1, 1'b0, 64'h1111, 0);
    sticky = 0;
    repeat (100) begin
      if (m_axis_tvalid) sticky = 1;
      tick();
    end
    check_eq("err_no_ack", sticky, 0);

    // Error counter saturation.
    for (int i = 0; i < 16; i++)
      send_frame(1'b1, 1'($urandom_range(0, 1)), {$urandom, $urandom}, 0);

    // New frame with value_ready held high: first ACK byte 2 cycles later.
    v = 64'hDEAD_BEEF_0123_4567;
    ack_q.push_back(1'b0);
    m_last_ack  = 1'b0;
    value_ready = 1'b1;
    pulse(1'b0, 1'b0, v);
    check_eq("lat_value_valid", value_valid, 1);
    check_eq("lat_value_data", value_data, v);
    check_eq("lat_ack_not_early", m_axis_tvalid, 0);
    tick();
    check_eq("lat_ack_2cyc", m_axis_tvalid, 1);
    value_ready = 1'b0;
    m_exp = 1'b1;
    $display("frame %0d: new bit=0 value=%h min latency", ++n_tr, v);
    wait_idle();
    check_counters();

    // Duplicate.
    send_frame(1'b0, 1'b0, 64'h2222, 0);

    // Backpressure: alternate tready with a 10-cycle stall on byte 30.
    tr_mode = 1;
    stall_n = 0;
    h0 = hs_total;
    n0 = acks_done;
    send_frame(1'b0, m_exp, {$urandom, $urandom}, 0);
    check_eq("bp_handshakes", hs_total - h0, ACK_BYTES);
    check_eq("bp_frames", acks_done - n0, 1);
    check_eq("bp_stall_seen", stall_n, 10);
    tr_mode = 0;

    // Drops in DELIVER and in SEND_ACK (an error frame counts only as a drop).
    v = {$urandom, $urandom};
    b = m_exp;
    ack_q.push_back(b);
    m_last_ack = b;
    pulse(1'b0, b, v);
    tick();
    pulse(1'b0, 1'($urandom_range(0, 1)), ~v);
    m_drop = sat(m_drop);
    check_eq("drop_value_valid", value_valid, 1);
    check_eq("drop_value_data", value_data, v);
    check_counters();
    tr_mode = 3;
    tick();
    value_ready = 1'b1;
    tick();
    value_ready = 1'b0;
    m_exp = !m_exp;
    check_eq("drop_ack_active", m_axis_tvalid, 1);
    pulse(1'b1, 1'b0, 64'h0);
    m_drop = sat(m_drop);
    check_counters();
    tr_mode = 0;
    $display("frame %0d: new bit=%0b value=%h with two dropped frames", ++n_tr, b, v);
    wait_idle();
    check_counters();

    // Idle timeout: the same ACK comes back after REACK idle cycles.
    t0 = mon_last_cyc;
    n0 = acks_done;
    ack_q.push_back(m_last_ack);
    n = 0;
    while (acks_done == n0 && n < 400) begin
      tick();
      n++;
    end
    check_eq("reack_seen", acks_done, n0 + 1);
    check_eq("reack_gap", mon_first_cyc - t0 - 1, REACK);
    check_counters();
    $display("reack %0d: bit=%0b after %0d idle cycles", ++n_tr, m_last_ack, mon_first_cyc - t0 - 1);

    // Frame on the very cycle the timer expires: the frame wins.
    repeat (REACK - 1) tick();
    v = {$urandom, $urandom};
    b = m_exp;
    ack_q.push_back(b);
    m_last_ack = b;
    pulse(1'b0, b, v);
    sticky = 0;
    repeat (20) begin
      if (m_axis_tvalid) sticky = 1;
      tick();
    end
    check_eq("prio_no_reack", sticky, 0);
    check_eq("prio_value_valid", value_valid, 1);
    check_eq("prio_value_data", value_data, v);
    value_ready = 1'b1;
    tick();
    value_ready = 1'b0;
    m_exp = !m_exp;
    $display("frame %0d: new bit=%0b value=%h on timer expiry", ++n_tr, b, v);
    wait_idle();
    check_counters();

    // Randomized traffic.
    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 6)) tick();
      send_frame(($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, $urandom_range(0, 4));
    end

    // Reset in the middle of an ACK.
    tr_mode = 2;
    v = {$urandom, $urandom};
    ack_q.push_back(m_exp);
    value_ready = 1'b1;
    pulse(1'b0, m_exp, v);
    tick();
    value_ready = 1'b0;
    n = 0;
    while (mon_idx != 20 && n < 200) begin
      tick();
      n++;
    end
    check_eq("rst_reach_byte20", mon_idx, 20);
    #2;
    aresetn = 1'b0;
    #1;
    m_exp  = 1'b0;
    m_dup  = 0;
    m_err  = 0;
    m_drop = 0;
    ack_q.delete();
    check_eq("midrst_tvalid", m_axis_tvalid, 0);
    check_eq("midrst_value_valid", value_valid, 0);
    check_counters();
    $display("reset %0d: asserted at ACK byte 20", ++n_tr);
    repeat (2) tick();
    aresetn = 1'b1;
    tr_mode = 0;
    tick();
    send_frame(1'b0, 1'b0, {$urandom, $urandom}, 1);

    repeat (5) tick();
    check_eq("end_queue_empty", ack_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
